pipe_hazard_ctrl: RTL and testbench

Central pipeline controller for the 5-stage core. Each cycle it decides whether to run, stall, bubble or squash, and drives the enable and flush inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB (EX/MEM enable feeds the execute stage `pipe_en`). Hazards handled: load-use, taken branch/jump redirect from the registered EX/MEM `PC_sel`, instruction-memory wait and data-memory wait. It also keeps saturating stall/flush performance counters and a data-memory timeout flag.

---
 rtl/pipe_hazard_if.sv | 45 ++++
 rtl/pipe_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_if.sv
// Hazard-controller bundle: hazard sources from the pipeline, stage controls and counters back.
// The master side is the pipeline and the slave side is pipe_hazard_ctrl.
interface pipe_hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             exmem_pc_sel;
    logic             imem_ready;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_en;
    logic             pc_redirect;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic [2:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               exmem_pc_sel, imem_ready, dmem_req, dmem_ready,
        input  pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, state, stall_cnt, flush_cnt,
               mem_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               exmem_pc_sel, imem_ready, dmem_req, dmem_ready,
        output pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, state, stall_cnt, flush_cnt,
               mem_timeout
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline controller: picks run/stall/bubble/squash each cycle and
// keeps saturating stall/flush counters plus a sticky data-memory timeout flag.
module pipe_hazard_ctrl #(
    parameter int CNT_W    = 16,
    parameter int WAIT_W   = 8,
    parameter int WAIT_MAX = 200
) (
    input  logic          clk,
    input  logic          rst,
    pipe_hazard_if.slave  hz
);
    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_DMEM_WAIT = 3'd1,
        ST_REDIRECT  = 3'd2,
        ST_LU_STALL  = 3'd3,
        ST_IMEM_WAIT = 3'd4
    } state_e;

    // Control word order: pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
    // ifid_flush, idex_flush, exmem_flush.
    localparam logic [8:0] CTL_IDLE  = 9'b0_0_0000_000;
    localparam logic [8:0] CTL_DWAIT = 9'b0_0_0000_000;
    localparam logic [8:0] CTL_REDIR = 9'b1_1_1111_111;
    localparam logic [8:0] CTL_LU    = 9'b0_0_0111_010;
    localparam logic [8:0] CTL_IWAIT = 9'b0_0_1111_100;
    localparam logic [8:0] CTL_RUN   = 9'b1_0_1111_000;

    logic          dmem_wait_s;
    logic          lu_hit_s;
    logic          stall_s;
    logic          flush_s;
    logic [8:0]    ctl_s;
    state_e        decision_s;
    state_e        state_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic          mem_timeout_r;

    assign dmem_wait_s = hz.dmem_req & ~hz.dmem_ready;
    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign lu_hit_s = hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                      ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                       (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));

    // Priority decision: reset, dmem wait, redirect, load-use, imem wait, run.
    always_comb begin
        ctl_s      = CTL_IDLE;
        decision_s = ST_RUN;
        if (rst) begin
            ctl_s      = CTL_IDLE;
            decision_s = ST_RUN;
        end else if (dmem_wait_s) begin
            ctl_s      = CTL_DWAIT;
            decision_s = ST_DMEM_WAIT;
        end else if (hz.exmem_pc_sel) begin
            ctl_s      = CTL_REDIR;
            decision_s = ST_REDIRECT;
        end else if (lu_hit_s) begin
            ctl_s      = CTL_LU;
            decision_s = ST_LU_STALL;
        end else if (!hz.imem_ready) begin
            ctl_s      = CTL_IWAIT;
            decision_s = ST_IMEM_WAIT;
        end else begin
            ctl_s      = CTL_RUN;
            decision_s = ST_RUN;
        end
    end

    // Classify the decided row for the performance counters.
    always_comb begin
        stall_s = 1'b0;
        flush_s = 1'b0;
        case (decision_s)
            ST_DMEM_WAIT, ST_LU_STALL, ST_IMEM_WAIT: stall_s = ~rst;
            ST_REDIRECT:                             flush_s = ~rst;
            default: begin
                stall_s = 1'b0;
                flush_s = 1'b0;
            end
        endcase
    end

    // Registered state, saturating counters and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_RUN;
            stall_cnt_r   <= {CNT_W{1'b0}};
            flush_cnt_r   <= {CNT_W{1'b0}};
            wait_cnt_r    <= {WAIT_W{1'b0}};
            mem_timeout_r <= 1'b0;
        end else begin
            state_r <= decision_s;
            if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
            if (flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end
            if (dmem_wait_s) begin
                if (wait_cnt_r != {WAIT_W{1'b1}}) begin
                    wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                end
                // Fires on the WAIT_MAX-th consecutive wait cycle.
                if (wait_cnt_r == WAIT_W'(WAIT_MAX - 1)) begin
                    mem_timeout_r <= 1'b1;
                end
            end else begin
                wait_cnt_r <= {WAIT_W{1'b0}};
            end
        end
    end

    assign hz.pc_en       = ctl_s[8];
    assign hz.pc_redirect = ctl_s[7];
    assign hz.ifid_en     = ctl_s[6];
    assign hz.idex_en     = ctl_s[5];
    assign hz.exmem_en    = ctl_s[4];
    assign hz.memwb_en    = ctl_s[3];
    assign hz.ifid_flush  = ctl_s[2];
    assign hz.idex_flush  = ctl_s[1];
    assign hz.exmem_flush = ctl_s[0];
    assign hz.state       = state_r;
    assign hz.stall_cnt   = stall_cnt_r;
    assign hz.flush_cnt   = flush_cnt_r;
    assign hz.mem_timeout = mem_timeout_r;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default-parameter instance and a small one
// (CNT_W=2, WAIT_MAX=4) share the same stimulus.
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   exp_stall;
    int   exp_flush;

    localparam logic [8:0] C_ZERO  = 9'b0_0_0000_000;
    localparam logic [8:0] C_RUN   = 9'b1_0_1111_000;
    localparam logic [8:0] C_REDIR = 9'b1_1_1111_111;
    localparam logic [8:0] C_LU    = 9'b0_0_0111_010;
    localparam logic [8:0] C_IWAIT = 9'b0_0_1111_100;

    pipe_hazard_if #(.CNT_W(16)) bus_a ();
    pipe_hazard_if #(.CNT_W(2))  bus_b ();

    pipe_hazard_ctrl dut_a (.clk(clk), .rst(rst), .hz(bus_a));
    pipe_hazard_ctrl #(.CNT_W(2), .WAIT_W(8), .WAIT_MAX(4)) dut_b (.clk(clk), .rst(rst), .hz(bus_b));

    assign bus_b.id_rs1       = bus_a.id_rs1;
    assign bus_b.id_rs2       = bus_a.id_rs2;
    assign bus_b.id_use_rs1   = bus_a.id_use_rs1;
    assign bus_b.id_use_rs2   = bus_a.id_use_rs2;
    assign bus_b.ex_rd        = bus_a.ex_rd;
    assign bus_b.ex_mem_read  = bus_a.ex_mem_read;
    assign bus_b.exmem_pc_sel = bus_a.exmem_pc_sel;
    assign bus_b.imem_ready   = bus_a.imem_ready;
    assign bus_b.dmem_req     = bus_a.dmem_req;
    assign bus_b.dmem_ready   = bus_a.dmem_ready;

    logic [8:0] ctl_a;
    logic [8:0] ctl_b;
    assign ctl_a = {bus_a.pc_en, bus_a.pc_redirect, bus_a.ifid_en, bus_a.idex_en, bus_a.exmem_en,
                    bus_a.memwb_en, bus_a.ifid_flush, bus_a.idex_flush, bus_a.exmem_flush};
    assign ctl_b = {bus_b.pc_en, bus_b.pc_redirect, bus_b.ifid_en, bus_b.idex_en, bus_b.exmem_en,
                    bus_b.memwb_en, bus_b.ifid_flush, bus_b.idex_flush, bus_b.exmem_flush};

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] ex_rd;
        logic       ex_mr;
        logic       pc_sel;
        logic       imem_rdy;
        logic       dreq;
        logic       drdy;
        logic [8:0] ctl;
        logic [2:0] st;
    } vec_t;

    vec_t vecs [11];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_a.id_rs1 = 5'd0; bus_a.id_rs2 = 5'd0;
        bus_a.id_use_rs1 = 1'b0; bus_a.id_use_rs2 = 1'b0;
        bus_a.ex_rd = 5'd0; bus_a.ex_mem_read = 1'b0;
        bus_a.exmem_pc_sel = 1'b0; bus_a.imem_ready = 1'b1;
        bus_a.dmem_req = 1'b0; bus_a.dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    task automatic apply(input vec_t v);
        bus_a.id_rs1 = v.rs1; bus_a.id_rs2 = v.rs2;
        bus_a.id_use_rs1 = v.use1; bus_a.id_use_rs2 = v.use2;
        bus_a.ex_rd = v.ex_rd; bus_a.ex_mem_read = v.ex_mr;
        bus_a.exmem_pc_sel = v.pc_sel; bus_a.imem_ready = v.imem_rdy;
        bus_a.dmem_req = v.dreq; bus_a.dmem_ready = v.drdy;
    endtask

    initial begin
        checks = 0; failures = 0; exp_stall = 0; exp_flush = 0;
        //             rs1    rs2    u1    u2    exrd   mr    psel  irdy  dreq  drdy  ctl      st
        vecs[0]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_LU,    3'd3};
        vecs[1]  = '{5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_LU,    3'd3};
        vecs[2]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_RUN,   3'd0};
        vecs[3]  = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_RUN,   3'd0};
        vecs[4]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_RUN,   3'd0};
        vecs[5]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_REDIR, 3'd2};
        vecs[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_IWAIT, 3'd4};
        vecs[7]  = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU,    3'd3};
        vecs[8]  = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, C_ZERO,  3'd1};
        vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, C_RUN,   3'd0};
        vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, C_REDIR, 3'd2};

        // Reset must outrank a pending dmem wait.
        idle();
        bus_a.dmem_req = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_ctl", 32'(ctl_a), 32'(C_ZERO));
        do_reset();
        idle();
        #1;
        chk("rst_state", 32'(bus_a.state), 32'd0);
        chk("rst_stall", 32'(bus_a.stall_cnt), 32'd0);
        chk("rst_flush", 32'(bus_a.flush_cnt), 32'd0);
        chk("rst_tmo", 32'(bus_a.mem_timeout), 32'd0);

        for (int i = 0; i < 11; i++) begin
            apply(vecs[i]);
            #1;
            chk($sformatf("vec%0d_ctl_a", i), 32'(ctl_a), 32'(vecs[i].ctl));
            chk($sformatf("vec%0d_ctl_b", i), 32'(ctl_b), 32'(vecs[i].ctl));
            step();
            if (vecs[i].st == 3'd1 || vecs[i].st == 3'd3 || vecs[i].st == 3'd4) exp_stall++;
            if (vecs[i].st == 3'd2) exp_flush++;
            chk($sformatf("vec%0d_state", i), 32'(bus_a.state), 32'(vecs[i].st));
            chk($sformatf("vec%0d_stall_a", i), 32'(bus_a.stall_cnt), 32'(exp_stall));
            chk($sformatf("vec%0d_flush_a", i), 32'(bus_a.flush_cnt), 32'(exp_flush));
            chk($sformatf("vec%0d_stall_b", i), 32'(bus_b.stall_cnt), 32'((exp_stall > 3) ? 3 : exp_stall));
        end

        // Redirect held through a 3-cycle dmem wait, then serviced.
        idle();
        do_reset();
        bus_a.dmem_req = 1'b1; bus_a.dmem_ready = 1'b0; bus_a.exmem_pc_sel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("dwait%0d_ctl", i), 32'(ctl_a), 32'(C_ZERO));
            step();
            chk($sformatf("dwait%0d_state", i), 32'(bus_a.state), 32'd1);
        end
        bus_a.dmem_ready = 1'b1;
        #1;
        chk("dwait_redir_ctl", 32'(ctl_a), 32'(C_REDIR));
        step();
        chk("dwait_redir_state", 32'(bus_a.state), 32'd2);
        chk("dwait_stall", 32'(bus_a.stall_cnt), 32'd3);
        chk("dwait_flush", 32'(bus_a.flush_cnt), 32'd1);

        // Timeout on the small instance after the 4th consecutive wait edge.
        idle();
        do_reset();
        bus_a.dmem_req = 1'b1; bus_a.dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("tmo_edge%0d", i + 1), 32'(bus_b.mem_timeout), (i >= 3) ? 32'd1 : 32'd0);
        end
        bus_a.dmem_ready = 1'b1;
        step();
        step();
        chk("tmo_sticky_b", 32'(bus_b.mem_timeout), 32'd1);
        chk("tmo_none_a", 32'(bus_a.mem_timeout), 32'd0);

        // Reset in the middle of a dmem wait clears everything.
        bus_a.dmem_ready = 1'b0;
        step();
        chk("midrst_pre_state", 32'(bus_b.state), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_ctl", 32'(ctl_b), 32'(C_ZERO));
        step();
        rst = 1'b0;
        chk("midrst_state", 32'(bus_b.state), 32'd0);
        chk("midrst_stall", 32'(bus_b.stall_cnt), 32'd0);
        chk("midrst_flush", 32'(bus_b.flush_cnt), 32'd0);
        chk("midrst_tmo", 32'(bus_b.mem_timeout), 32'd0);

        // Counter saturation: five imem waits.
        idle();
        do_reset();
        bus_a.imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("sat_stall_b", 32'(bus_b.stall_cnt), 32'd3);
        chk("sat_stall_a", 32'(bus_a.stall_cnt), 32'd5);
        chk("sat_state", 32'(bus_a.state), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
